// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard / forwarding controller.
// Stage records carry just enough of each in-flight instruction to detect RAW hazards.
package pipe_pkg;

    localparam int RD_W         = 8;
    localparam int ZERO_REG_DEF = 31;
    localparam int FWD_RF       = 0;

    typedef struct packed {
        logic            valid;
        logic [RD_W-1:0] rd;
        logic            regwrite;
        logic            load;
    } stage_info_t;

    // Width of a forwarding select able to name stages 0..depth.
    function automatic int fwd_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Priority compare of one source operand against the in-flight stage records.
// Purely combinational; the youngest matching producer wins.
module hazard_match
    import pipe_pkg::*;
#(
    parameter int DEPTH     = 3,
    parameter int AW        = 5,
    parameter int ZERO_REG  = ZERO_REG_DEF,
    parameter int WB_BYPASS = 0,
    parameter int FW        = fwd_w(DEPTH)
) (
    input  logic                    useReg,
    input  logic [AW-1:0]           regAddr,
    input  stage_info_t [DEPTH-1:0] stages,
    output logic [FW-1:0]           fwd,
    output logic                    loadHit
);

    logic hitLoad;

    always_comb begin
        fwd     = FW'(FWD_RF);
        hitLoad = 1'b0;
        loadHit = 1'b0;
        if (useReg && (regAddr != AW'(ZERO_REG))) begin
            // Walk oldest to youngest so the last assignment is the youngest hit.
            for (int k = DEPTH; k >= 1; k--) begin
                if (((k < DEPTH) || (WB_BYPASS != 0)) &&
                    stages[k-1].valid && stages[k-1].regwrite &&
                    (stages[k-1].rd == RD_W'(regAddr))) begin
                    fwd     = FW'(k);
                    hitLoad = stages[k-1].load;
                end
            end
            loadHit = (fwd == FW'(1)) && hitLoad;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Forwarding selects, load-use interlock and branch flush for the RF stage; zero-cycle outputs.
// A load-use pair holds IF/RF for exactly one cycle and injects a bubble into EX.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int DEPTH     = 3,
    parameter int AW        = 5,
    parameter int ZERO_REG  = ZERO_REG_DEF,
    parameter int WB_BYPASS = 0,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rf_valid,
    input  logic [AW-1:0]    rf_rn,
    input  logic [AW-1:0]    rf_rm,
    input  logic             rf_use_rn,
    input  logic             rf_use_rm,
    input  logic [AW-1:0]    rf_rd,
    input  logic             rf_regwrite,
    input  logic             rf_load,
    input  logic             br_taken,
    output logic [2:0]       fwd_a,
    output logic [2:0]       fwd_b,
    output logic             stall_if,
    output logic             bubble_ex,
    output logic             flush_if,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int FW = fwd_w(DEPTH);

    stage_info_t [DEPTH-1:0] stageQ;
    stage_info_t             newEntry;
    logic [FW-1:0]           fwdA;
    logic [FW-1:0]           fwdB;
    logic                    loadHitA;
    logic                    loadHitB;
    logic                    stallInt;
    logic                    flushInt;
    logic [CNT_W-1:0]        stallCnt;
    logic [CNT_W-1:0]        flushCnt;

    hazard_match #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .ZERO_REG (ZERO_REG),
        .WB_BYPASS(WB_BYPASS),
        .FW       (FW)
    ) u_match_rn (
        .useReg (rf_use_rn),
        .regAddr(rf_rn),
        .stages (stageQ),
        .fwd    (fwdA),
        .loadHit(loadHitA)
    );

    hazard_match #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .ZERO_REG (ZERO_REG),
        .WB_BYPASS(WB_BYPASS),
        .FW       (FW)
    ) u_match_rm (
        .useReg (rf_use_rm),
        .regAddr(rf_rm),
        .stages (stageQ),
        .fwd    (fwdB),
        .loadHit(loadHitB)
    );

    assign stallInt = rf_valid && (loadHitA || loadHitB);
    // A stalled branch is re-evaluated next cycle once the load data can be forwarded.
    assign flushInt = br_taken && rf_valid && !stallInt;

    always_comb begin
        newEntry = '0;
        if (rf_valid && !stallInt) begin
            newEntry.valid    = 1'b1;
            newEntry.rd       = RD_W'(rf_rd);
            newEntry.regwrite = rf_regwrite;
            newEntry.load     = rf_load;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stageQ <= '0;
        end else begin
            stageQ <= {stageQ[DEPTH-2:0], newEntry};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (stallInt && (stallCnt != {CNT_W{1'b1}})) begin
                stallCnt <= stallCnt + CNT_W'(1);
            end
            if (flushInt && (flushCnt != {CNT_W{1'b1}})) begin
                flushCnt <= flushCnt + CNT_W'(1);
            end
        end
    end

    assign fwd_a       = 3'(fwdA);
    assign fwd_b       = 3'(fwdB);
    assign stall_if    = stallInt;
    assign bubble_ex   = stallInt;
    assign flush_if    = flushInt;
    assign stall_count = stallCnt;
    assign flush_count = flushCnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scenario bench for pipe_hazard_ctrl: rows of RF-stage stimulus with expected outputs queued at drive time.
module tb_pipe_hazard_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          rf_valid;
    logic [4:0]    rf_rn;
    logic [4:0]    rf_rm;
    logic          rf_use_rn;
    logic          rf_use_rm;
    logic [4:0]    rf_rd;
    logic          rf_regwrite;
    logic          rf_load;
    logic          br_taken;
    logic [2:0]    fwd_a;
    logic [2:0]    fwd_b;
    logic          stall_if;
    logic          bubble_ex;
    logic          flush_if;
    logic [CW-1:0] stall_count;
    logic [CW-1:0] flush_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rst;
        logic       v;
        logic [4:0] rn;
        logic [4:0] rm;
        logic       un;
        logic       um;
        logic [4:0] rd;
        logic       rw;
        logic       ld;
        logic       br;
        logic [2:0] ea;
        logic [2:0] eb;
        logic       es;
        logic       ef;
    } row_t;

    logic [8:0] expQ[$];

    pipe_hazard_ctrl #(
        .DEPTH    (3),
        .AW       (5),
        .ZERO_REG (31),
        .WB_BYPASS(0),
        .CNT_W    (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rf_valid   (rf_valid),
        .rf_rn      (rf_rn),
        .rf_rm      (rf_rm),
        .rf_use_rn  (rf_use_rn),
        .rf_use_rm  (rf_use_rm),
        .rf_rd      (rf_rd),
        .rf_regwrite(rf_regwrite),
        .rf_load    (rf_load),
        .br_taken   (br_taken),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b),
        .stall_if   (stall_if),
        .bubble_ex  (bubble_ex),
        .flush_if   (flush_if),
        .stall_count(stall_count),
        .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    function automatic row_t mk(input logic rst, v, input logic [4:0] rn, rm,
                                input logic un, um, input logic [4:0] rd,
                                input logic rw, ld, br, input logic [2:0] ea, eb,
                                input logic es, ef);
        row_t r;
        r.rst = rst; r.v = v; r.rn = rn; r.rm = rm; r.un = un; r.um = um;
        r.rd = rd; r.rw = rw; r.ld = ld; r.br = br;
        r.ea = ea; r.eb = eb; r.es = es; r.ef = ef;
        return r;
    endfunction

    function automatic row_t nop();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic idle();
        rf_valid = 0; rf_rn = 0; rf_rm = 0; rf_use_rn = 0; rf_use_rm = 0;
        rf_rd = 0; rf_regwrite = 0; rf_load = 0; br_taken = 0;
    endtask

    task automatic drive(input row_t r);
        reset = r.rst; rf_valid = r.v; rf_rn = r.rn; rf_rm = r.rm;
        rf_use_rn = r.un; rf_use_rm = r.um; rf_rd = r.rd;
        rf_regwrite = r.rw; rf_load = r.ld; br_taken = r.br;
        expQ.push_back({r.ea, r.eb, r.es, r.es, r.ef});
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [8:0] o;
        reset = 1'b1;
        idle();
        rf_valid = 1; rf_rn = 5'd1; rf_use_rn = 1; rf_rm = 5'd2; rf_use_rm = 1;
        #3;
        o = {fwd_a, fwd_b, stall_if, bubble_ex, flush_if};
        checks++;
        if (o !== 9'd0) begin failures++; $display("FAIL reset_outputs got=%b exp=%b", o, 9'd0); end
        checks++;
        if (stall_count !== '0 || flush_count !== '0) begin
            failures++;
            $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_count, flush_count);
        end
        @(negedge clk);
        reset = 1'b0;
        #2;
        o = {fwd_a, fwd_b, stall_if, bubble_ex, flush_if};
        checks++;
        if (o !== 9'd0) begin failures++; $display("FAIL reset_release got=%b exp=%b", o, 9'd0); end
    endtask

    task automatic test_back_to_back();
        row_t rows[$];
        logic [8:0] e, o;
        do_reset();
        rows.push_back(mk(0, 1, 2, 3, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(mk(0, 1, 1, 3, 1, 1, 2, 1, 0, 0, 1, 0, 0, 0));
        rows.push_back(nop());
        rows.push_back(mk(0, 1, 2, 1, 1, 1, 6, 1, 0, 0, 2, 0, 0, 0));
        rows.push_back(nop());
        foreach (rows[i]) begin
            @(negedge clk); drive(rows[i]); #2;
            e = expQ.pop_front();
            o = {fwd_a, fwd_b, stall_if, bubble_ex, flush_if};
            checks++;
            if (o !== e) begin failures++; $display("FAIL back_to_back row%0d got=%b exp=%b", i, o, e); end
        end
        @(negedge clk); #1;
        checks++;
        if (stall_count !== 0 || flush_count !== 0) begin
            failures++;
            $display("FAIL back_to_back_counters got=%0d/%0d exp=0/0", stall_count, flush_count);
        end
    endtask

    task automatic test_youngest();
        row_t rows[$];
        logic [8:0] e, o;
        do_reset();
        rows.push_back(mk(0, 1, 8, 9, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(mk(0, 1, 10, 11, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(mk(0, 1, 1, 1, 1, 1, 12, 1, 0, 0, 1, 1, 0, 0));
        rows.push_back(mk(0, 1, 8, 9, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(nop());
        rows.push_back(mk(0, 1, 1, 1, 1, 0, 12, 1, 0, 0, 2, 0, 0, 0));
        rows.push_back(mk(0, 1, 8, 9, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(nop());
        rows.push_back(nop());
        rows.push_back(mk(0, 1, 1, 1, 1, 1, 12, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(nop());
        foreach (rows[i]) begin
            @(negedge clk); drive(rows[i]); #2;
            e = expQ.pop_front();
            o = {fwd_a, fwd_b, stall_if, bubble_ex, flush_if};
            checks++;
            if (o !== e) begin failures++; $display("FAIL youngest row%0d got=%b exp=%b", i, o, e); end
        end
    endtask

    task automatic test_load_use();
        row_t rows[$];
        logic [8:0] e, o;
        do_reset();
        rows.push_back(mk(0, 1, 20, 0, 1, 0, 4, 1, 1, 0, 0, 0, 0, 0));
        rows.push_back(mk(0, 1, 4, 4, 1, 1, 5, 1, 0, 0, 1, 1, 1, 0));
        rows.push_back(mk(0, 1, 4, 4, 1, 1, 5, 1, 0, 0, 2, 2, 0, 0));
        rows.push_back(mk(0, 1, 20, 0, 1, 0, 6, 1, 1, 0, 0, 0, 0, 0));
        rows.push_back(mk(0, 0, 6, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        rows.push_back(mk(0, 1, 6, 0, 1, 0, 7, 1, 0, 0, 2, 0, 0, 0));
        rows.push_back(nop());
        foreach (rows[i]) begin
            @(negedge clk); drive(rows[i]); #2;
            e = expQ.pop_front();
            o = {fwd_a, fwd_b, stall_if, bubble_ex, flush_if};
            checks++;
            if (o !== e) begin failures++; $display("FAIL load_use row%0d got=%b exp=%b", i, o, e); end
        end
        @(negedge clk); #1;
        checks++;
        if (stall_count !== 1 || flush_count !== 0) begin
            failures++;
            $display("FAIL load_use_counters got=%0d/%0d exp=1/0", stall_count, flush_count);
        end
    endtask

    task automatic test_zero_reg();
        row_t rows[$];
        logic [8:0] e, o;
        do_reset();
        rows.push_back(mk(0, 1, 20, 0, 1, 0, 31, 1, 1, 0, 0, 0, 0, 0));
        rows.push_back(mk(0, 1, 31, 31, 1, 1, 12, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(mk(0, 1, 20, 0, 1, 0, 31, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(mk(0, 1, 31, 12, 1, 1, 13, 1, 0, 0, 0, 2, 0, 0));
        rows.push_back(nop());
        foreach (rows[i]) begin
            @(negedge clk); drive(rows[i]); #2;
            e = expQ.pop_front();
            o = {fwd_a, fwd_b, stall_if, bubble_ex, flush_if};
            checks++;
            if (o !== e) begin failures++; $display("FAIL zero_reg row%0d got=%b exp=%b", i, o, e); end
        end
        @(negedge clk); #1;
        checks++;
        if (stall_count !== 0) begin
            failures++;
            $display("FAIL zero_reg_stall_count got=%0d exp=0", stall_count);
        end
    endtask

    task automatic test_branch();
        row_t rows[$];
        logic [8:0] e, o;
        do_reset();
        rows.push_back(mk(0, 1, 0, 9, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        rows.push_back(mk(0, 1, 20, 0, 1, 0, 9, 1, 1, 0, 0, 0, 0, 0));
        rows.push_back(mk(0, 1, 0, 9, 0, 1, 0, 0, 0, 1, 0, 1, 1, 0));
        rows.push_back(mk(0, 1, 0, 9, 0, 1, 0, 0, 0, 1, 0, 2, 0, 1));
        rows.push_back(nop());
        foreach (rows[i]) begin
            @(negedge clk); drive(rows[i]); #2;
            e = expQ.pop_front();
            o = {fwd_a, fwd_b, stall_if, bubble_ex, flush_if};
            checks++;
            if (o !== e) begin failures++; $display("FAIL branch row%0d got=%b exp=%b", i, o, e); end
        end
        @(negedge clk); #1;
        checks++;
        if (stall_count !== 1 || flush_count !== 2) begin
            failures++;
            $display("FAIL branch_counters got=%0d/%0d exp=1/2", stall_count, flush_count);
        end
    endtask

    task automatic test_reset_mid();
        row_t rows[$];
        logic [8:0] e, o;
        do_reset();
        rows.push_back(mk(0, 1, 20, 0, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0));
        rows.push_back(mk(0, 1, 1, 21, 1, 1, 2, 1, 0, 0, 1, 0, 1, 0));
        rows.push_back(mk(0, 1, 1, 21, 1, 1, 2, 1, 0, 0, 2, 0, 0, 0));
        rows.push_back(mk(0, 1, 2, 22, 1, 1, 3, 1, 0, 0, 1, 0, 0, 0));
        rows.push_back(mk(1, 1, 3, 2, 1, 1, 12, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(mk(0, 1, 3, 2, 1, 1, 12, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(mk(0, 1, 12, 1, 1, 1, 13, 1, 0, 0, 1, 0, 0, 0));
        rows.push_back(nop());
        foreach (rows[i]) begin
            @(negedge clk); drive(rows[i]); #2;
            e = expQ.pop_front();
            o = {fwd_a, fwd_b, stall_if, bubble_ex, flush_if};
            checks++;
            if (o !== e) begin failures++; $display("FAIL reset_mid row%0d got=%b exp=%b", i, o, e); end
        end
        @(negedge clk); #1;
        checks++;
        if (stall_count !== 0 || flush_count !== 0) begin
            failures++;
            $display("FAIL reset_mid_counters got=%0d/%0d exp=0/0", stall_count, flush_count);
        end
    endtask

    task automatic test_saturate();
        row_t rows[$];
        logic [8:0] e, o;
        do_reset();
        for (int n = 0; n < 17; n++) rows.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        rows.push_back(nop());
        foreach (rows[i]) begin
            @(negedge clk); drive(rows[i]); #2;
            e = expQ.pop_front();
            o = {fwd_a, fwd_b, stall_if, bubble_ex, flush_if};
            checks++;
            if (o !== e) begin failures++; $display("FAIL saturate row%0d got=%b exp=%b", i, o, e); end
        end
        @(negedge clk); #1;
        checks++;
        if (flush_count !== {CW{1'b1}} || stall_count !== 0) begin
            failures++;
            $display("FAIL saturate_counters got=%0d/%0d exp=0/%0d", stall_count, flush_count, (1 << CW) - 1);
        end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_back_to_back();
        test_youngest();
        test_load_use();
        test_zero_reg();
        test_branch();
        test_reset_mid();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised hazard and forwarding controller for the pipelined ARM-subset CPU.
- Tracks destination-register info for every in-flight instruction past the RF stage.
- Drives per-operand forwarding selects, load-use interlock (stall plus bubble) and IF flush on an accelerated branch.
- Keeps saturating stall and flush counters for performance checks.
- Replaces ad-hoc forwarding compares in the RF stage; sits beside the IF2RF and RF2EX pipeline registers.

Parameters:
DEPTH, 3, in-flight stages tracked after RF (1=EX, 2=MEM, 3=WB); range 2..6.
AW, 5, register address width.
ZERO_REG, 31, register index never forwarded (XZR).
WB_BYPASS, 0, 1 means stage DEPTH is a forwarding source; 0 means the regfile's mid-cycle write covers it.
CNT_W, 32, counter width.

Ports:
clk  in  1  rising-edge clock.
reset  in  1  asynchronous, active-high reset.
rf_valid  in  1  RF stage holds a real instruction.
rf_rn  in  AW  first source register.
rf_rm  in  AW  second source register (already muxed by Reg2Loc).
rf_use_rn  in  1  instruction reads rf_rn.
rf_use_rm  in  1  instruction reads rf_rm.
rf_rd  in  AW  destination register.
rf_regwrite  in  1  instruction writes rf_rd.
rf_load  in  1  instruction is LDUR/LDURB.
br_taken  in  1  branch resolved taken in RF this cycle.
fwd_a  out  3  Rn source: 0 = regfile, k = stage k result.
fwd_b  out  3  Rm source, same encoding.
stall_if  out  1  hold PC and the IF2RF register.
bubble_ex  out  1  load a NOP into the RF2EX register.
flush_if  out  1  squash the instruction entering IF2RF.
stall_count  out  CNT_W  stall cycles seen.
flush_count  out  CNT_W  flushes issued.

Behaviour:
- State: entries s[1..DEPTH], each holding {valid, rd, regwrite, load}.
- Reset (async):
  - all entries valid=0.
  - counters = 0.
  - with no valid entries, every combinational output reads 0.
- Shift on each rising edge:
  - s[1] <= (rf_valid && !stall_if) ? {1, rf_rd, rf_regwrite, rf_load} : bubble (all 0).
  - s[k] <= s[k-1] for k = 2..DEPTH.
  - the last entry drops off the end.
- Operand match, evaluated for Rn and Rm independently:
  - candidate stages k = 1..DEPTH-1, plus DEPTH when WB_BYPASS=1.
  - a hit requires use && reg != ZERO_REG && s[k].valid && s[k].regwrite && s[k].rd == reg.
  - fwd = smallest hitting k (youngest producer wins); 0 if there is no hit or the operand is unused.
- Load-use interlock:
  - stall_if = rf_valid && (Rn hits at k=1 with s[1].load || Rm hits at k=1 with s[1].load).
  - bubble_ex = stall_if.
  - latency: zero-cycle combinational from inputs and state; exactly one stall cycle per load-use pair.
- Flush:
  - flush_if = br_taken && rf_valid && !stall_if.
  - when stall and branch occur together, the stall wins: no flush, and the branch is re-evaluated next cycle with correct operands.
- fwd_a and fwd_b stay meaningful during a stall but are ignored downstream.
- Counters:
  - stall_count increments on each cycle with stall_if=1.
  - flush_count increments on each cycle with flush_if=1.
  - both saturate at all-ones and do not wrap.
- Reset mid-operation: all entries are invalidated immediately; no forwarding from pre-reset instructions.
- X31 as destination never produces a hit. A load to X31 never stalls.

Decomposition:
- Package pipe_pkg holds:
  - stage_info_t struct {valid, rd, regwrite, load}.
  - ZERO_REG default.
  - FWD_RF = 0 encoding constant.
  - function fwd_w(DEPTH).
- Sub-module hazard_match: one operand's priority compare across the entries, returning {fwd, load_hit}. Instantiated twice (Rn, Rm).

Test Plan:
- ADDS X1 then ADD X2,X1,X3 back-to-back -> fwd_a=1 in the cycle the ADD is in RF; no stall; counters stay 0.
- ADD X1 at EX and SUB X1 at MEM, RF reads X1 -> fwd=1 (youngest wins); remove the EX producer -> fwd=2.
- LDUR X4 then ADD X5,X4,X4 -> stall_if=bubble_ex=1 for exactly 1 cycle; next cycle fwd_a=fwd_b=2; stall_count=1.
- Producer writes X31 at EX, consumer reads X31 -> fwd=0, no stall even if the producer is a load.
- CBZ in RF with br_taken=1, no hazard -> flush_if=1, flush_count=1; with a load-use on the CBZ operand -> stall for 1 cycle, flush the next cycle.
- Assert reset while 3 producers are in flight -> all outputs 0 immediately; after release, a consumer of those registers gets fwd=0.
